// File: rtl/id_resp_pkg.sv
// Shared types for the response/ID-queue matcher: FSM state encoding and default metadata type.
package id_resp_pkg;

  typedef logic [15:0] meta_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EMIT   = 2'd2
  } id_resp_state_e;

endpackage

// File: rtl/id_resp_matcher.sv
// Merges ID-tagged response beats with metadata looked up in an id_queue; out_valid two cycles after accept
// when granted, one beat per two cycles sustained; stalls rsp_ready while the lookup or output is pending.
module id_resp_matcher #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter type         meta_t     = id_resp_pkg::meta_t,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic [ID_WIDTH-1:0]       rsp_id_i,
  input  logic [DATA_WIDTH-1:0]     rsp_data_i,
  input  logic                      rsp_last_i,
  input  logic                      rsp_valid_i,
  output logic                      rsp_ready_o,

  output logic [ID_WIDTH-1:0]       q_id_o,
  output logic                      q_pop_o,
  output logic                      q_req_o,
  input  logic                      q_gnt_i,
  input  logic [$bits(meta_t)-1:0]  q_data_i,
  input  logic                      q_data_valid_i,

  output logic [ID_WIDTH-1:0]       out_id_o,
  output logic [DATA_WIDTH-1:0]     out_data_o,
  output logic                      out_last_o,
  output logic [$bits(meta_t)-1:0]  out_meta_o,
  output logic                      out_err_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,

  output logic [CNT_WIDTH-1:0]      orphan_cnt_o
);

  import id_resp_pkg::*;

  id_resp_state_e state, state_nxt;

  logic [ID_WIDTH-1:0]   in_id;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  logic accept;
  logic lookup_done;

  assign rsp_ready_o = (state == ST_IDLE) || ((state == ST_EMIT) && out_ready_i);
  assign accept      = rsp_valid_i && rsp_ready_o;

  // Queue outputs are gated to zero outside LOOKUP so a stale last beat can never pop.
  assign q_req_o     = (state == ST_LOOKUP);
  assign q_id_o      = q_req_o ? in_id : '0;
  assign q_pop_o     = q_req_o && in_last;
  assign lookup_done = q_req_o && q_gnt_i;

  assign out_valid_o = (state == ST_EMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rsp_valid_i) state_nxt = ST_LOOKUP;
      ST_LOOKUP: if (q_gnt_i)     state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (out_ready_i) state_nxt = rsp_valid_i ? ST_LOOKUP : ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_id   <= '0;
      in_data <= '0;
      in_last <= 1'b0;
    end else if (accept) begin
      in_id   <= rsp_id_i;
      in_data <= rsp_data_i;
      in_last <= rsp_last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_id_o   <= '0;
      out_data_o <= '0;
      out_last_o <= 1'b0;
      out_meta_o <= '0;
      out_err_o  <= 1'b0;
    end else if (lookup_done) begin
      out_id_o   <= in_id;
      out_data_o <= in_data;
      out_last_o <= in_last;
      out_meta_o <= q_data_valid_i ? q_data_i : '0;
      out_err_o  <= !q_data_valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      orphan_cnt_o <= '0;
    end else if (lookup_done && !q_data_valid_i && (orphan_cnt_o != '1)) begin
      orphan_cnt_o <= orphan_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_resp_matcher.sv
// Scoreboard bench: a behavioural per-ID queue serves lookups; a reference model predicts each emitted beat.
module tb_id_resp_matcher;

  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [IDW-1:0] rsp_id_i;
  logic [DW-1:0]  rsp_data_i;
  logic           rsp_last_i, rsp_valid_i, rsp_ready_o;
  logic [IDW-1:0] q_id_o;
  logic           q_pop_o, q_req_o, q_gnt_i;
  logic [15:0]    q_data_i;
  logic           q_data_valid_i;
  logic [IDW-1:0] out_id_o;
  logic [DW-1:0]  out_data_o;
  logic           out_last_o;
  logic [15:0]    out_meta_o;
  logic           out_err_o, out_valid_o, out_ready_i;
  logic [CW-1:0]  orphan_cnt_o;

  always #5 clk = ~clk;

  id_resp_matcher #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .meta_t(logic [15:0]), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rsp_id_i(rsp_id_i), .rsp_data_i(rsp_data_i), .rsp_last_i(rsp_last_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .q_id_o(q_id_o), .q_pop_o(q_pop_o), .q_req_o(q_req_o), .q_gnt_i(q_gnt_i),
    .q_data_i(q_data_i), .q_data_valid_i(q_data_valid_i),
    .out_id_o(out_id_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_meta_o(out_meta_o), .out_err_o(out_err_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .orphan_cnt_o(orphan_cnt_o)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           last;
    logic [15:0]    meta;
    logic           err;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] env_q[16][$];
  logic [15:0] ref_q[16][$];
  int          hs_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          gnt_mode = 0;
  int          rdy_mode = 0;
  int          ref_cnt = 0;
  bit          pop_pending = 1'b0;
  logic [IDW-1:0] pop_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic load(input int id, input logic [15:0] meta);
    env_q[id].push_back(meta);
    ref_q[id].push_back(meta);
  endtask

  // Reference: each accepted beat reads the oldest entry of its ID; the last beat consumes it.
  task automatic ref_push();
    exp_t e;
    int id;
    id = int'(rsp_id_i);
    e.id = rsp_id_i; e.data = rsp_data_i; e.last = rsp_last_i;
    if (ref_q[id].size() > 0) begin
      e.meta = ref_q[id][0];
      e.err  = 1'b0;
      if (rsp_last_i) void'(ref_q[id].pop_front());
    end else begin
      e.meta = 16'h0;
      e.err  = 1'b1;
      if (ref_cnt < CNT_MAX) ref_cnt++;
    end
    e.cnt = CW'(ref_cnt);
    exp_q.push_back(e);
  endtask

  task automatic start_beat(input int id, input logic [DW-1:0] data, input bit last);
    rsp_id_i    = IDW'(id);
    rsp_data_i  = data;
    rsp_last_i  = last;
    rsp_valid_i = 1'b1;
  endtask

  task automatic wait_accept(output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    while (!done && waited < 300) begin
      @(negedge clk);
      if (rsp_ready_o) done = 1'b1;
      else waited++;
    end
    if (done) ref_push();
    else begin
      total++; bad++;
      $display("FAIL accept_timeout: actual=no_accept required=accept id=%0d", rsp_id_i);
    end
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
  endtask

  task automatic send_beat(input int id, input logic [DW-1:0] data, input bit last);
    int w;
    start_beat(id, data, last);
    wait_accept(w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Environment: behavioural id_queue answering lookups and applying granted pops.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (pop_pending) begin
        if (env_q[pop_id].size() > 0) void'(env_q[pop_id].pop_front());
        pop_pending = 1'b0;
      end
      q_gnt_i     = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (env_q[q_id_o].size() > 0) begin
        q_data_valid_i = 1'b1;
        q_data_i       = env_q[q_id_o][0];
      end else begin
        q_data_valid_i = 1'b0;
        q_data_i       = 16'($urandom);
      end
    end
  end

  // Monitor: scoreboard pop on output handshake plus hold-stability checks.
  bit          hold_o = 1'b0, hold_q = 1'b0;
  logic [53:0] saved_o;
  logic [4:0]  saved_q;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_o = 1'b0; hold_q = 1'b0; pop_pending = 1'b0;
      end else begin
        pop_pending = q_req_o && q_gnt_i && q_pop_o;
        pop_id      = q_id_o;
        if (hold_o)
          chk("out_hold_stable", 64'({out_valid_o, out_id_o, out_data_o, out_last_o, out_meta_o, out_err_o}),
              64'({1'b1, saved_o}));
        if (hold_q)
          chk("q_hold_stable", 64'({q_req_o, q_id_o, q_pop_o}), 64'({1'b1, saved_q}));
        if (out_valid_o && out_ready_i) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: actual id=%0d required=no_output", out_id_o);
          end else begin
            e = exp_q.pop_front();
            chk("out_id",   64'(out_id_o),     64'(e.id));
            chk("out_data", 64'(out_data_o),   64'(e.data));
            chk("out_last", 64'(out_last_o),   64'(e.last));
            chk("out_meta", 64'(out_meta_o),   64'(e.meta));
            chk("out_err",  64'(out_err_o),    64'(e.err));
            chk("orphan_cnt", 64'(orphan_cnt_o), 64'(e.cnt));
          end
        end
        hold_o  = out_valid_o && !out_ready_i;
        saved_o = {out_id_o, out_data_o, out_last_o, out_meta_o, out_err_o};
        hold_q  = q_req_o && !q_gnt_i;
        saved_q = {q_id_o, q_pop_o};
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic single_beat_check(input string tag);
    load(3, 16'hBEEF);
    send_beat(3, 32'h1111_0003, 1'b1);
    @(negedge clk);
    chk({tag, "_lookup_n1"}, 64'({q_req_o, q_pop_o, q_id_o, out_valid_o}), 64'({1'b1, 1'b1, 4'd3, 1'b0}));
    @(negedge clk);
    chk({tag, "_valid_n2"}, 64'(out_valid_o), 64'(1));
    @(posedge clk); #1;
    drain();
    chk({tag, "_cnt"}, 64'(orphan_cnt_o), 64'(0));
  endtask

  initial begin
    int w;
    rst_n = 1'b0; rsp_valid_i = 1'b0; rsp_id_i = '0; rsp_data_i = '0; rsp_last_i = 1'b0;
    q_gnt_i = 1'b1; q_data_i = '0; q_data_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", 64'(rsp_ready_o), 64'(1));
    chk("rst_q", 64'({q_req_o, q_pop_o, q_id_o}), 64'(0));
    chk("rst_out", 64'({out_valid_o, out_id_o, out_data_o, out_last_o, out_meta_o, out_err_o}), 64'(0));
    chk("rst_cnt", 64'(orphan_cnt_o), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    single_beat_check("s1");

    load(5, 16'h0012);
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) send_beat(5, 32'h5000 + i, i == 3);
    drain();
    chk("burst_outs", 64'(hs_cyc.size()), 64'(4));
    for (int i = 1; i < hs_cyc.size(); i++) chk("burst_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(2));
    chk("burst_popped", 64'(env_q[5].size()), 64'(0));

    send_beat(7, 32'h7777, 1'b1);
    drain();
    chk("orphan_cnt1", 64'(orphan_cnt_o), 64'(1));

    load(4, 16'h4444);
    gnt_mode = 2;
    send_beat(4, 32'h4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("gnt_hold", 64'({q_req_o, q_id_o, q_pop_o, rsp_ready_o}), 64'({1'b1, 4'd4, 1'b1, 1'b0}));
    end
    @(posedge clk); #1;
    gnt_mode = 0;
    @(negedge clk);
    chk("gnt_rel_n0", 64'(out_valid_o), 64'(0));
    @(negedge clk);
    chk("gnt_rel_n1", 64'(out_valid_o), 64'(1));
    @(posedge clk); #1;
    drain();

    load(1, 16'h0101);
    load(2, 16'h0202);
    rdy_mode = 2;
    send_beat(1, 32'hA1, 1'b1);
    start_beat(2, 32'hA2, 1'b1);
    w = 0;
    while (!out_valid_o && w < 50) begin @(negedge clk); w++; end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("rdy_hold", 64'({out_valid_o, rsp_ready_o, out_id_o}), 64'({1'b1, 1'b0, 4'd1}));
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    wait_accept(w);
    chk("rdy_rel_same_cycle", 64'(w), 64'(0));
    drain();

    gnt_mode = 1; rdy_mode = 1;
    for (int id = 0; id < 8; id++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) load(id, 16'($urandom));
    end
    for (int i = 0; i < 80; i++) begin
      send_beat($urandom_range(0, 7), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    gnt_mode = 0; rdy_mode = 0;

    for (int i = 0; i < CNT_MAX + 4; i++) send_beat(15, 32'hF000 + i, 1'b1);
    drain();
    chk("orphan_saturated", 64'(orphan_cnt_o), 64'(CNT_MAX));

    load(6, 16'h0606);
    gnt_mode = 2;
    send_beat(6, 32'h66, 1'b1);
    @(negedge clk);
    chk("pre_rst_lookup", 64'(q_req_o), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_clear", 64'({q_req_o, q_pop_o, out_valid_o, orphan_cnt_o}), 64'(0));
    exp_q.delete();
    ref_cnt = 0;
    void'(ref_q[6].pop_front());
    load(6, 16'h0606);
    void'(env_q[6].pop_back());
    gnt_mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_nopop", 64'({q_req_o, q_pop_o}), 64'(0));
    end
    @(posedge clk); #1;
    chk("post_rst_entry_kept", 64'(env_q[6].size()), 64'(1));

    single_beat_check("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
